// File: rtl/alct_tx_pkg.sv
// Shared types and bit positions for the ALCT transmit frame builder.
// Holds FSM state encodings, frame width and tx bit-position constants.
package alct_tx_pkg;

  localparam int FRAME_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_GAP
  } seq_state_t;

  // tx_1st bit positions
  localparam int B_L1A   = 0;
  localparam int B_BX0   = 1;
  localparam int B_INJ   = 2;
  localparam int B_TRG   = 3;
  localparam int B_FRAME = 4;
  localparam int B_START = 5;
  localparam int B_LO    = 6;

  // tx_2nd bit positions
  localparam int B_HI    = 0;
  localparam int B_PAR   = 4;

endpackage

// File: rtl/alct_tx_frame_builder_if.sv
// Sequencer command bus: write strobe/data in, status out.
// master = command source, slave = frame builder.
interface alct_tx_frame_builder_if #(
  parameter int CMD_WIDTH = 16
);

  logic                 seq_cmd_wr;
  logic [CMD_WIDTH-1:0] seq_cmd_data;
  logic                 seq_busy;
  logic                 seq_full;
  logic                 seq_overflow;
  logic [15:0]          seq_sent_cnt;

  modport master (
    output seq_cmd_wr,
    output seq_cmd_data,
    input  seq_busy,
    input  seq_full,
    input  seq_overflow,
    input  seq_sent_cnt
  );

  modport slave (
    input  seq_cmd_wr,
    input  seq_cmd_data,
    output seq_busy,
    output seq_full,
    output seq_overflow,
    output seq_sent_cnt
  );

endinterface

// File: rtl/alct_tx_cmd_fifo.sv
// Synchronous command FIFO: clock, clr, wr/wr_data, rd/rd_data,
// full, empty, count. A write while full is taken only with a read.
module alct_tx_cmd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          clr,
  input  logic          wr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd & ~empty;
  assign do_wr   = wr & (~full | do_rd);
  assign rd_data = mem[rp];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wp] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alct_tx_frame_builder.sv
// ALCT per-bx tx frame builder: fast bits merged with FIFO-queued
// sequencer commands. Ports: clock, clr, tx_en, l1a, bx0, ext_inject,
// ext_trig, seq (command bus slave), tx_1st, tx_2nd.
// Option: ALCT_TX_PARITY_EN puts odd parity of the word in tx_2nd[4].
module alct_tx_frame_builder
  import alct_tx_pkg::*;
#(
  parameter int CMD_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BX     = 1
) (
  input  logic               clock,
  input  logic               clr,
  input  logic               tx_en,
  input  logic               l1a,
  input  logic               bx0,
  input  logic               ext_inject,
  input  logic               ext_trig,
  alct_tx_frame_builder_if.slave seq,
  output logic [FRAME_W-1:0] tx_1st,
  output logic [FRAME_W-1:0] tx_2nd
);

  localparam int NBYTES = CMD_WIDTH / 8;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GW = 4;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  seq_state_t st, st_n;
  logic [IW-1:0]        idx, idx_n;
  logic [GW-1:0]        gap, gap_n;
  logic                 pop, done;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic [CMD_WIDTH-1:0] f_rd_data;
  logic                 f_full, f_empty;
  logic [CW-1:0]        f_count;
  logic                 ovf_q;
  logic [15:0]          cnt_q;
  logic                 frame_b, start_b;
  logic [7:0]           byte_n;
  logic [FRAME_W-1:0]   w1, w2;

  alct_tx_cmd_fifo #(
    .W     (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock   (clock),
    .clr     (clr),
    .wr      (seq.seq_cmd_wr),
    .wr_data (seq.seq_cmd_data),
    .rd      (pop),
    .rd_data (f_rd_data),
    .full    (f_full),
    .empty   (f_empty),
    .count   (f_count)
  );

  assign seq.seq_busy     = (st != ST_IDLE) | ~f_empty;
  assign seq.seq_full     = (f_count == CW'(FIFO_DEPTH));
  assign seq.seq_overflow = ovf_q;
  assign seq.seq_sent_cnt = cnt_q;

  always_ff @(posedge clock) begin
    if (clr) begin
      st  <= ST_IDLE;
      idx <= '0;
      gap <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
      gap <= gap_n;
    end
  end

  // tx_en=0 leaves every next value equal to the current one
  always_comb begin
    st_n  = st;
    idx_n = idx;
    gap_n = gap;
    pop   = 1'b0;
    done  = 1'b0;
    if (tx_en) begin
      unique case (st)
        ST_IDLE: begin
          if (!f_empty) begin
            pop  = 1'b1;
            st_n = ST_START;
          end
        end
        ST_START: begin
          st_n  = ST_DATA;
          idx_n = '0;
        end
        ST_DATA: begin
          if (idx == IW'(NBYTES - 1)) begin
            done  = 1'b1;
            idx_n = '0;
            gap_n = '0;
            st_n  = (GAP_BX > 0) ? ST_GAP : ST_IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap == GW'(GAP_BX - 1)) st_n = ST_IDLE;
          else gap_n = gap + 1'b1;
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  // Decoded from the next state so the seq bits land in the
  // same output register edge as the state change.
  always_comb begin
    frame_b = 1'b0;
    start_b = 1'b0;
    byte_n  = 8'h00;
    unique case (st_n)
      ST_START: begin
        frame_b = 1'b1;
        start_b = 1'b1;
      end
      ST_DATA: begin
        frame_b = 1'b1;
        byte_n  = 8'(cmd_q >> {idx_n, 3'b000});
      end
      default: ;
    endcase
  end

  always_comb begin
    w1 = '0;
    w2 = '0;
    w1[B_L1A]     = l1a;
    w1[B_BX0]     = bx0;
    w1[B_INJ]     = ext_inject;
    w1[B_TRG]     = ext_trig;
    w1[B_FRAME]   = frame_b;
    w1[B_START]   = start_b;
    w1[B_LO +: 4] = byte_n[3:0];
    w2[B_HI +: 4] = byte_n[7:4];
`ifdef ALCT_TX_PARITY_EN
    w2[B_PAR]     = ~(^{w2, w1});
`else
`endif
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      tx_1st <= '0;
      tx_2nd <= '0;
      cmd_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      tx_1st <= tx_en ? w1 : '0;
      tx_2nd <= tx_en ? w2 : '0;
      if (pop) cmd_q <= f_rd_data;
      if (seq.seq_cmd_wr && f_full && !pop) ovf_q <= 1'b1;
      if (done && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alct_tx_frame_builder.sv
// Self-checking bench for alct_tx_frame_builder: directed cases
// plus randomized traffic against a slot-schedule reference model.
module tb_alct_tx_frame_builder;

  localparam int CW    = 16;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;
  localparam int NB    = CW / 8;

  logic clock = 1'b0;
  logic clr = 1'b1;
  logic tx_en = 1'b0;
  logic l1a = 1'b0;
  logic bx0 = 1'b0;
  logic ext_inject = 1'b0;
  logic ext_trig = 1'b0;
  logic [9:0] tx_1st;
  logic [9:0] tx_2nd;

  alct_tx_frame_builder_if #(.CMD_WIDTH(CW)) sif();

  alct_tx_frame_builder #(
    .CMD_WIDTH  (CW),
    .FIFO_DEPTH (DEPTH),
    .GAP_BX     (GAP)
  ) dut (
    .clock      (clock),
    .clr        (clr),
    .tx_en      (tx_en),
    .l1a        (l1a),
    .bx0        (bx0),
    .ext_inject (ext_inject),
    .ext_trig   (ext_trig),
    .seq        (sif),
    .tx_1st     (tx_1st),
    .tx_2nd     (tx_2nd)
  );

  always #12 clock = ~clock;

  typedef struct {
    logic [19:0] w;
    bit          inc;
  } slot_t;

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] q[$];
  slot_t         pl[$];
  logic [19:0]   m_tx = '0;
  logic          m_ovf = 1'b0;
  logic [15:0]   m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One command becomes: START now, then NB data words, GAP gap
  // words, one idle word; the word after the last byte bumps the count.
  task automatic model();
    logic [19:0]   seqw;
    logic [CW-1:0] c;
    logic [7:0]    b;
    slot_t         s;
    if (clr) begin
      q.delete();
      pl.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
      m_tx  = '0;
      return;
    end
    seqw = '0;
    if (tx_en) begin
      if (pl.size() > 0) begin
        s = pl.pop_front();
        seqw = s.w;
        if (s.inc && m_cnt != 16'hFFFF) m_cnt++;
      end else if (q.size() > 0) begin
        c = q.pop_front();
        seqw = 20'h00030;
        for (int i = 0; i < NB; i++) begin
          b = 8'((c >> (8 * i)) & 'hFF);
          s.w = '0;
          s.w[4] = 1'b1;
          s.w[9:6] = b[3:0];
          s.w[13:10] = b[7:4];
          s.inc = 1'b0;
          pl.push_back(s);
        end
        for (int i = 0; i <= GAP; i++) begin
          s.w = '0;
          s.inc = (i == 0);
          pl.push_back(s);
        end
      end
    end
    if (sif.seq_cmd_wr) begin
      if (q.size() < DEPTH) q.push_back(sif.seq_cmd_data);
      else m_ovf = 1'b1;
    end
    if (tx_en) begin
      m_tx = seqw;
      m_tx[0] = l1a;
      m_tx[1] = bx0;
      m_tx[2] = ext_inject;
      m_tx[3] = ext_trig;
`ifdef ALCT_TX_PARITY_EN
      m_tx[14] = ~(^m_tx);
`endif
    end else begin
      m_tx = '0;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model();
    @(negedge clock);
    chk("tx", {12'h0, tx_2nd, tx_1st}, {12'h0, m_tx});
    chk("busy", sif.seq_busy, (pl.size() > 0) || (q.size() > 0));
    chk("full", sif.seq_full, q.size() == DEPTH);
    chk("ovf", sif.seq_overflow, m_ovf);
    chk("cnt", sif.seq_sent_cnt, m_cnt);
  endtask

  task automatic wr_cmd(input logic [CW-1:0] d);
    sif.seq_cmd_wr = 1'b1;
    sif.seq_cmd_data = d;
    cyc();
    sif.seq_cmd_wr = 1'b0;
  endtask

  initial begin
    sif.seq_cmd_wr = 1'b0;
    sif.seq_cmd_data = '0;

    cyc();
    chk("rst_tx1", tx_1st, 0);
    chk("rst_tx2", tx_2nd, 0);
    chk("rst_busy", sif.seq_busy, 0);
    chk("rst_cnt", sif.seq_sent_cnt, 0);
    clr = 1'b0;
    tx_en = 1'b1;
    cyc();

    l1a = 1'b1;
    cyc();
    chk("t1_l1a", tx_1st, 10'h001);
    l1a = 1'b0;
    cyc();
    chk("t1_off", tx_1st, 10'h000);

    wr_cmd(16'hA53C);
    cyc();
    chk("t2_start", tx_1st, 10'h030);
    cyc();
    chk("t2_d0_lo", tx_1st, 10'h310);
    chk("t2_d0_hi", tx_2nd[3:0], 4'h3);
    cyc();
    chk("t2_d1_lo", tx_1st, 10'h150);
    chk("t2_d1_hi", tx_2nd[3:0], 4'hA);
    cyc();
    chk("t2_gap", tx_1st, 10'h000);
    chk("t2_cnt", sif.seq_sent_cnt, 1);
    cyc();

    wr_cmd(16'hA53C);
    cyc();
    cyc();
    bx0 = 1'b1;
    cyc();
    chk("t5_bx0", tx_1st, 10'h152);
    chk("t5_hi", tx_2nd[3:0], 4'hA);
    bx0 = 1'b0;
    cyc();
    cyc();

    for (int i = 0; i < 6; i++) wr_cmd(16'(16'h1111 * (i + 1)));
    chk("t3_ovf", sif.seq_overflow, 1);
    for (int i = 0; i < 40; i++) cyc();
    chk("t3_cnt", sif.seq_sent_cnt, 7);

    wr_cmd(16'h5AA5);
    cyc();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t4_tx1", tx_1st, 0);
    chk("t4_busy", sif.seq_busy, 0);
    chk("t4_cnt", sif.seq_sent_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t4_quiet", tx_1st, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 299) == 0);
      tx_en = ($urandom_range(0, 7) != 0);
      l1a = ($urandom_range(0, 5) == 0);
      bx0 = ($urandom_range(0, 5) == 0);
      ext_inject = ($urandom_range(0, 7) == 0);
      ext_trig = ($urandom_range(0, 7) == 0);
      sif.seq_cmd_wr = ($urandom_range(0, 3) == 0);
      sif.seq_cmd_data = 16'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
